// File: rtl/calc_driver.sv
// Command-driven initiator/checker for the 8-bit calculator: issues one operation,
// waits its pipeline latency, captures the result and flags mismatches against a golden value.
module calc_driver #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_modo,
    output logic             calc_en,
    output logic [WIDTH-1:0] calc_a,
    output logic [WIDTH-1:0] calc_b,
    output logic [1:0]       calc_modo,
    input  logic [WIDTH-1:0] calc_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_c,
    output logic             res_err,
    output logic [CNT_W-1:0] err_count
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             calc_en_reg, calc_en_next;
    logic [WIDTH-1:0] calc_a_reg, calc_a_next;
    logic [WIDTH-1:0] calc_b_reg, calc_b_next;
    logic [1:0]       calc_modo_reg, calc_modo_next;
    logic             res_valid_reg, res_valid_next;
    logic [WIDTH-1:0] res_c_reg, res_c_next;
    logic             res_err_reg, res_err_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;
    logic [WIDTH-1:0] golden;

    // Golden value is derived from the operands actually presented to the calculator.
    always_comb begin
        golden = '0;
        case (calc_modo_reg)
            2'b00: golden = calc_a_reg + calc_b_reg;
            2'b01: golden = calc_a_reg - calc_b_reg;
            2'b10: golden = calc_a_reg * calc_b_reg;
            2'b11: golden = {calc_a_reg[WIDTH-2:0], 1'b0};
            default: golden = '0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        calc_en_next   = calc_en_reg;
        calc_a_next    = calc_a_reg;
        calc_b_next    = calc_b_reg;
        calc_modo_next = calc_modo_reg;
        res_valid_next = res_valid_reg;
        res_c_next     = res_c_reg;
        res_err_next   = res_err_reg;
        err_count_next = err_count_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    calc_a_next    = cmd_a;
                    calc_b_next    = cmd_b;
                    calc_modo_next = cmd_modo;
                    calc_en_next   = 1'b1;
                    cnt_next       = '0;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_reg == CW'(LAT - 1)) begin
                    calc_en_next = 1'b0;
                    state_next   = CAPTURE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            CAPTURE: begin
                res_c_next     = calc_c;
                res_err_next   = (calc_c != golden);
                res_valid_next = 1'b1;
                state_next     = DONE;
                // Saturate rather than wrap so a long self-test never reads back as clean.
                if ((calc_c != golden) && (err_count_reg != {CNT_W{1'b1}}))
                    err_count_next = err_count_reg + CNT_W'(1);
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            calc_en_reg   <= 1'b0;
            calc_a_reg    <= '0;
            calc_b_reg    <= '0;
            calc_modo_reg <= '0;
            res_valid_reg <= 1'b0;
            res_c_reg     <= '0;
            res_err_reg   <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            calc_en_reg   <= calc_en_next;
            calc_a_reg    <= calc_a_next;
            calc_b_reg    <= calc_b_next;
            calc_modo_reg <= calc_modo_next;
            res_valid_reg <= res_valid_next;
            res_c_reg     <= res_c_next;
            res_err_reg   <= res_err_next;
            err_count_reg <= err_count_next;
        end
    end

    assign cmd_ready = (state_reg == IDLE) && !rst;
    assign calc_en   = calc_en_reg;
    assign calc_a    = calc_a_reg;
    assign calc_b    = calc_b_reg;
    assign calc_modo = calc_modo_reg;
    assign res_valid = res_valid_reg;
    assign res_c     = res_c_reg;
    assign res_err   = res_err_reg;
    assign err_count = err_count_reg;
endmodule

// File: tb/tb_calc_driver.sv
// Directed bench for calc_driver with a 2-stage calculator model and fault injection;
// a second instance with a 2-bit error counter exercises saturation.
module tb_calc_driver;
    localparam int WIDTH = 8;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready, cmd_ready_s;
    logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
    logic [1:0]       cmd_modo = '0;
    logic             calc_en, calc_en_s;
    logic [WIDTH-1:0] calc_a, calc_b, calc_a_s, calc_b_s;
    logic [1:0]       calc_modo, calc_modo_s;
    logic [WIDTH-1:0] calc_c;
    logic             res_valid, res_valid_s;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_c, res_c_s;
    logic             res_err, res_err_s;
    logic [7:0]       err_count;
    logic [1:0]       err_count_s;

    logic             fault = 1'b0;
    logic [WIDTH-1:0] p1, p2;
    int               n_checks = 0;
    int               n_pass = 0;

    always #5 clk = ~clk;

    calc_driver #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_modo(cmd_modo),
        .calc_en(calc_en), .calc_a(calc_a), .calc_b(calc_b), .calc_modo(calc_modo),
        .calc_c(calc_c), .res_valid(res_valid), .res_ready(res_ready),
        .res_c(res_c), .res_err(res_err), .err_count(err_count)
    );

    calc_driver #(.WIDTH(WIDTH), .LAT(LAT), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_s),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_modo(cmd_modo),
        .calc_en(calc_en_s), .calc_a(calc_a_s), .calc_b(calc_b_s), .calc_modo(calc_modo_s),
        .calc_c(calc_c), .res_valid(res_valid_s), .res_ready(res_ready),
        .res_c(res_c_s), .res_err(res_err_s), .err_count(err_count_s)
    );

    // Calculator model: two register stages; fault forces the output to zero.
    always_ff @(posedge clk) begin
        case (calc_modo)
            2'b00: p1 <= calc_a + calc_b;
            2'b01: p1 <= calc_a - calc_b;
            2'b10: p1 <= calc_a * calc_b;
            default: p1 <= {calc_a[WIDTH-2:0], 1'b0};
        endcase
        p2 <= p1;
    end
    assign calc_c = fault ? '0 : p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and returns cycles from accept to res_valid (99 if never accepted).
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        output int lat);
        int w = 0;
        while (!cmd_ready && w < 20) begin step(); w++; end
        if (!cmd_ready) begin lat = 99; return; end
        cmd_a = a; cmd_b = b; cmd_modo = m; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 20) begin step(); lat++; end
    endtask

    task automatic take();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %0b want 0", cmd_ready); else n_pass++;
        n_checks++; if (calc_en !== 1'b0) $display("FAIL reset_calc_en got %0b want 0", calc_en); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %0b want 0", res_valid); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count got %0d want 0", err_count); else n_pass++;
        n_checks++; if (calc_a !== 8'd0 || calc_b !== 8'd0 || calc_modo !== 2'd0)
            $display("FAIL reset_operands got %0d/%0d/%0d want 0/0/0", calc_a, calc_b, calc_modo); else n_pass++;
        n_checks++; if (res_c !== 8'd0 || res_err !== 1'b0)
            $display("FAIL reset_result got %0d/%0b want 0/0", res_c, res_err); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready got %0b want 1", cmd_ready); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_add();
        int lat;
        send(8'd100, 8'd27, 2'b00, lat);
        n_checks++; if (lat !== 3) $display("FAIL add_latency got %0d want 3", lat); else n_pass++;
        n_checks++; if (res_c !== 8'd127 || res_err !== 1'b0)
            $display("FAIL add_result got %0d err %0b want 127 err 0", res_c, res_err); else n_pass++;
        n_checks++; if (err_count !== 8'd0) $display("FAIL add_err_count got %0d want 0", err_count); else n_pass++;
        take();
        $display("add 100+27 -> %0d err %0b", res_c, res_err);
    endtask

    task automatic test_sub_mul();
        int lat;
        send(8'd5, 8'd10, 2'b01, lat);
        n_checks++; if (lat !== 3 || res_c !== 8'd251 || res_err !== 1'b0)
            $display("FAIL sub_wrap got lat %0d c %0d err %0b want lat 3 c 251 err 0", lat, res_c, res_err); else n_pass++;
        take();
        $display("sub 5-10 -> %0d", res_c);
        send(8'd20, 8'd13, 2'b10, lat);
        n_checks++; if (lat !== 3 || res_c !== 8'd4 || res_err !== 1'b0)
            $display("FAIL mul_trunc got lat %0d c %0d err %0b want lat 3 c 4 err 0", lat, res_c, res_err); else n_pass++;
        take();
        $display("mul 20*13 -> %0d", res_c);
    endtask

    task automatic test_shift_mismatch();
        int lat;
        send(8'h81, 8'h55, 2'b11, lat);
        n_checks++; if (lat !== 3 || res_c !== 8'h02 || res_err !== 1'b0)
            $display("FAIL shift got lat %0d c %0h err %0b want lat 3 c 02 err 0", lat, res_c, res_err); else n_pass++;
        take();
        $display("shl 0x81 -> 0x%0h", res_c);
        fault = 1'b1;
        send(8'd3, 8'd4, 2'b00, lat);
        fault = 1'b0;
        n_checks++; if (lat !== 3 || res_c !== 8'h00 || res_err !== 1'b1)
            $display("FAIL mismatch got lat %0d c %0h err %0b want lat 3 c 00 err 1", lat, res_c, res_err); else n_pass++;
        n_checks++; if (err_count !== 8'd1) $display("FAIL mismatch_count got %0d want 1", err_count); else n_pass++;
        take();
        $display("faulty add 3+4 -> %0d err %0b count %0d", res_c, res_err, err_count);
    endtask

    task automatic test_backpressure();
        int lat;
        send(8'd9, 8'd6, 2'b10, lat);
        n_checks++; if (lat !== 3 || res_c !== 8'd54) $display("FAIL bp_result got lat %0d c %0d want lat 3 c 54", lat, res_c); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = i[0];
            cmd_a = 8'd200; cmd_b = 8'd1; cmd_modo = 2'b00;
            step();
            n_checks++; if (res_valid !== 1'b1 || res_c !== 8'd54 || res_err !== 1'b0)
                $display("FAIL bp_hold cyc %0d got v %0b c %0d e %0b want 1/54/0", i, res_valid, res_c, res_err); else n_pass++;
            n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_ready cyc %0d got %0b want 0", i, cmd_ready); else n_pass++;
            n_checks++; if (calc_a !== 8'd9 || calc_en !== 1'b0)
                $display("FAIL bp_no_accept cyc %0d got a %0d en %0b want 9/0", i, calc_a, calc_en); else n_pass++;
        end
        cmd_valid = 1'b0;
        take();
        n_checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL bp_after_handshake got ready %0b valid %0b want 1/0", cmd_ready, res_valid); else n_pass++;
        $display("backpressure held 5 cycles, result %0d", res_c);
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        cmd_a = 8'd50; cmd_b = 8'd60; cmd_modo = 2'b00; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        n_checks++; if (calc_en !== 1'b1) $display("FAIL mid_issue got en %0b want 1", calc_en); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL mid_rst_ready got %0b want 0", cmd_ready); else n_pass++;
        step();
        rst = 1'b0;
        n_checks++; if (calc_en !== 1'b0 || res_valid !== 1'b0 || err_count !== 8'd0 || calc_a !== 8'd0)
            $display("FAIL mid_rst_state got en %0b v %0b cnt %0d a %0d want 0/0/0/0", calc_en, res_valid, err_count, calc_a); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) seen++;
            step();
        end
        n_checks++; if (seen !== 0) $display("FAIL mid_no_result got %0d valid cycles want 0", seen); else n_pass++;
        send(8'd11, 8'd22, 2'b00, lat);
        n_checks++; if (lat !== 3 || res_c !== 8'd33 || res_err !== 1'b0)
            $display("FAIL mid_next_cmd got lat %0d c %0d err %0b want lat 3 c 33 err 0", lat, res_c, res_err); else n_pass++;
        take();
        $display("reset mid-op recovered, next result %0d", res_c);
    endtask

    task automatic test_saturation();
        int lat;
        logic [1:0] exp_s;
        for (int i = 0; i < 5; i++) begin
            fault = 1'b1;
            send(8'(i + 1), 8'd1, 2'b00, lat);
            fault = 1'b0;
            exp_s = (i < 3) ? 2'(i + 1) : 2'd3;
            n_checks++; if (lat !== 3 || res_err_s !== 1'b1 || err_count_s !== exp_s)
                $display("FAIL sat_count2 n %0d got lat %0d err %0b cnt %0d want 3/1/%0d", i, lat, res_err_s, err_count_s, exp_s); else n_pass++;
            n_checks++; if (err_count !== 8'(i + 1))
                $display("FAIL sat_count8 n %0d got %0d want %0d", i, err_count, i + 1); else n_pass++;
            take();
            $display("mismatch %0d: count2 %0d count8 %0d", i, err_count_s, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_mul();
        test_shift_mismatch();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
